// File: rtl/btb_predictor_if.sv
// Fetch-side lookup and execute-side update bus of the branch target buffer.
interface btb_predictor_if;
    logic [31:0] i_pc_IF;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_upd_vld;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic        i_upd_pred_taken;
    logic [31:0] i_upd_pred_target;
    logic        o_mispred;
    logic [31:0] o_mispred_cnt;
    logic [31:0] o_hit_cnt;

    // Predictor side
    modport slave (
        input  i_pc_IF, i_upd_vld, i_upd_pc, i_upd_taken, i_upd_target,
               i_upd_pred_taken, i_upd_pred_target,
        output o_pred_taken, o_pred_target, o_mispred, o_mispred_cnt, o_hit_cnt
    );

    // Pipeline side
    modport master (
        output i_pc_IF, i_upd_vld, i_upd_pc, i_upd_taken, i_upd_target,
               i_upd_pred_taken, i_upd_pred_target,
        input  o_pred_taken, o_pred_target, o_mispred, o_mispred_cnt, o_hit_cnt
    );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational off the registered table; one update per cycle.
module btb_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic           i_clk,
    input  logic           i_reset,
    btb_predictor_if.slave bus
);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [31:0]        target [ENTRIES];
    logic [1:0]         ctr    [ENTRIES];

    logic [31:0] mispred_cnt;
    logic [31:0] hit_cnt;

    // Word-aligned PCs: the two low bits carry no index or tag information
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.i_pc_IF[1:0], bus.i_upd_pc[1:0]};

    // Lookup path
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic             l_taken;

    assign l_idx   = bus.i_pc_IF[IDX_W+1:2];
    assign l_tag   = bus.i_pc_IF[31:IDX_W+2];
    assign l_hit   = valid[l_idx] && (tag[l_idx] == l_tag);
    assign l_taken = l_hit && ctr[l_idx][1];

    assign bus.o_pred_taken  = l_taken;
    assign bus.o_pred_target = l_taken ? target[l_idx] : bus.i_pc_IF + 32'd4;

    // Update path
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             mispred;

    assign u_idx = bus.i_upd_pc[IDX_W+1:2];
    assign u_tag = bus.i_upd_pc[31:IDX_W+2];
    assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

    // Direction wrong, or taken to a different place than predicted
    assign mispred = bus.i_upd_vld &&
                     ((bus.i_upd_pred_taken != bus.i_upd_taken) ||
                      (bus.i_upd_taken && (bus.i_upd_pred_target != bus.i_upd_target)));

    assign bus.o_mispred     = mispred;
    assign bus.o_mispred_cnt = mispred_cnt;
    assign bus.o_hit_cnt     = hit_cnt;

    // Table write: train on hit, allocate only on a taken miss
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= 2'b01;
            end
        end else if (bus.i_upd_vld) begin
            if (u_hit) begin
                if (bus.i_upd_taken) begin
                    ctr[u_idx]    <= (ctr[u_idx] == 2'b11) ? 2'b11 : ctr[u_idx] + 2'd1;
                    target[u_idx] <= bus.i_upd_target;
                end else begin
                    ctr[u_idx]    <= (ctr[u_idx] == 2'b00) ? 2'b00 : ctr[u_idx] - 2'd1;
                end
            end else if (bus.i_upd_taken) begin
                valid[u_idx]  <= 1'b1;
                tag[u_idx]    <= u_tag;
                target[u_idx] <= bus.i_upd_target;
                ctr[u_idx]    <= 2'b10;
            end
        end
    end

    // Statistics counters, free-running with natural wrap
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            mispred_cnt <= '0;
            hit_cnt     <= '0;
        end else begin
            if (mispred)                  mispred_cnt <= mispred_cnt + 32'd1;
            if (bus.i_upd_vld && u_hit)   hit_cnt     <= hit_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Directed vector bench for btb_predictor (ENTRIES=16).
module tb_btb_predictor;
    logic i_clk;
    logic i_reset;

    btb_predictor_if bus ();

    btb_predictor #(.ENTRIES(16)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vld;
        logic [31:0] upc;
        logic        tkn;
        logic [31:0] tgt;
        logic        ptkn;
        logic [31:0] ptgt;
        logic [31:0] pc;
        logic        e_ptkn;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_mcnt;
        logic [31:0] e_hcnt;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [31:0] upc, input logic tkn,
                         input logic [31:0] tgt, input logic ptkn, input logic [31:0] ptgt,
                         input logic [31:0] pc);
        bus.i_upd_vld         = vld;
        bus.i_upd_pc          = upc;
        bus.i_upd_taken       = tkn;
        bus.i_upd_target      = tgt;
        bus.i_upd_pred_taken  = ptkn;
        bus.i_upd_pred_target = ptgt;
        bus.i_pc_IF           = pc;
    endtask

    task automatic chk_out(input string tag, input logic ept, input logic [31:0] etg,
                           input logic emis, input logic [31:0] emc, input logic [31:0] ehc);
        chk({tag, " pred_taken"},  {31'd0, bus.o_pred_taken}, {31'd0, ept});
        chk({tag, " pred_target"}, bus.o_pred_target, etg);
        chk({tag, " mispred"},     {31'd0, bus.o_mispred}, {31'd0, emis});
        chk({tag, " mispred_cnt"}, bus.o_mispred_cnt, emc);
        chk({tag, " hit_cnt"},     bus.o_hit_cnt, ehc);
    endtask

    function automatic vec_t mk(logic vld, logic [31:0] upc, logic tkn, logic [31:0] tgt,
                                logic ptkn, logic [31:0] ptgt, logic [31:0] pc,
                                logic ept, logic [31:0] etg, logic emis,
                                logic [31:0] emc, logic [31:0] ehc);
        vec_t v;
        v.vld = vld; v.upc = upc; v.tkn = tkn; v.tgt = tgt; v.ptkn = ptkn; v.ptgt = ptgt;
        v.pc = pc; v.e_ptkn = ept; v.e_ptgt = etg; v.e_mis = emis; v.e_mcnt = emc; v.e_hcnt = ehc;
        return v;
    endfunction

    initial begin
        // Outputs observed before the edge that applies the row's update.
        //          vld upc           tkn tgt           ptk ptgt          pc            ept etgt          mis mcnt hcnt
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h100,      0, 32'h104,      0, 0, 0));
        vecs.push_back(mk(1, 32'h100,       1, 32'h200,       0, 32'h0,         32'h100,      0, 32'h104,      1, 0, 0));
        vecs.push_back(mk(1, 32'h100,       0, 32'h0,         1, 32'h200,       32'h100,      1, 32'h200,      1, 1, 0));
        vecs.push_back(mk(1, 32'h100,       0, 32'h0,         0, 32'h0,         32'h100,      0, 32'h104,      0, 2, 1));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h100,      0, 32'h104,      0, 2, 2));
        vecs.push_back(mk(1, 32'h100,       0, 32'h0,         0, 32'h0,         32'h104,      0, 32'h108,      0, 2, 2));
        vecs.push_back(mk(1, 32'h100,       1, 32'h200,       0, 32'h0,         32'h100,      0, 32'h104,      1, 2, 3));
        vecs.push_back(mk(1, 32'h140,       1, 32'h300,       0, 32'h0,         32'h100,      0, 32'h104,      1, 3, 4));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h100,      0, 32'h104,      0, 4, 4));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h140,      1, 32'h300,      0, 4, 4));
        vecs.push_back(mk(1, 32'h140,       1, 32'h300,       1, 32'h300,       32'h140,      1, 32'h300,      0, 4, 4));
        vecs.push_back(mk(1, 32'h140,       1, 32'h300,       1, 32'h300,       32'h140,      1, 32'h300,      0, 4, 5));
        vecs.push_back(mk(1, 32'h140,       1, 32'h300,       1, 32'h300,       32'h140,      1, 32'h300,      0, 4, 6));
        vecs.push_back(mk(1, 32'h140,       1, 32'h300,       1, 32'h300,       32'h140,      1, 32'h300,      0, 4, 7));
        vecs.push_back(mk(1, 32'h140,       0, 32'h0,         1, 32'h300,       32'h140,      1, 32'h300,      1, 4, 8));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h140,      1, 32'h300,      0, 5, 9));
        vecs.push_back(mk(1, 32'h140,       1, 32'h380,       1, 32'h300,       32'h140,      1, 32'h300,      1, 5, 9));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h140,      1, 32'h380,      0, 6, 10));
        vecs.push_back(mk(0, 32'h180,       1, 32'h500,       0, 32'h0,         32'h180,      0, 32'h184,      0, 6, 10));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h180,      0, 32'h184,      0, 6, 10));
        vecs.push_back(mk(1, 32'h104,       0, 32'h0,         0, 32'h0,         32'h104,      0, 32'h108,      0, 6, 10));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h104,      0, 32'h108,      0, 6, 10));
        vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0, 32'h0,         32'hFFFFFFFC, 0, 32'h0,        0, 6, 10));

        // Reset state, checked while reset is still held
        i_reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'h100);
        #2;
        chk_out("reset", 0, 32'h104, 0, 0, 0);
        @(posedge i_clk);
        #1 i_reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].vld, vecs[i].upc, vecs[i].tkn, vecs[i].tgt,
                  vecs[i].ptkn, vecs[i].ptgt, vecs[i].pc);
            #3;
            chk_out($sformatf("vec%0d", i), vecs[i].e_ptkn, vecs[i].e_ptgt,
                    vecs[i].e_mis, vecs[i].e_mcnt, vecs[i].e_hcnt);
            @(posedge i_clk);
            #1;
        end

        // Asynchronous reset mid-operation; mispred stays combinational during reset
        drive(1, 32'h140, 1, 32'h300, 0, 32'h0, 32'h140);
        #1 i_reset = 1'b0;
        #1;
        chk_out("async_rst", 0, 32'h144, 1, 0, 0);
        @(posedge i_clk);
        #1;
        chk_out("rst_held", 0, 32'h144, 1, 0, 0);
        i_reset = 1'b1;

        // First edge after release sees an empty table: taken update allocates, no hit
        #3;
        chk_out("post_rst", 0, 32'h144, 1, 0, 0);
        @(posedge i_clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 32'h140);
        #1;
        chk_out("post_rst_alloc", 1, 32'h300, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 32'h100);
        #1;
        chk_out("post_rst_old", 0, 32'h104, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
